// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RISC datapath (regfile, A/B/C, status, ALU selects).
// Latency start->done: ADD/AND 6, CMP/MOV/MVN 5, MOVI 3, illegal 2 cycles; outputs registered from next state.
// Backpressure: start accepted only while idle (busy=0); no queueing. Optional SEQ_PERF_CNT_EN adds counters.
module instr_sequencer #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [15:0]        instr,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [REGBITS-1:0] readnum,
    output logic [REGBITS-1:0] writenum,
    output logic               write,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               asel,
    output logic               bsel,
    output logic               vsel,
    output logic [1:0]         shift,
    output logic [WIDTH-1:0]   sximm,
    output logic               addSubVals,
    output logic               andVals,
    output logic               notBVal,
    output logic               sub
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]        instrCount,
    output logic [15:0]        cycleCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE, S_WRITE_IMM, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_MOVI, K_MOV, K_ADD, K_CMP, K_AND, K_MVN, K_ILL
    } kind_t;

    typedef struct packed {
        logic               busy;
        logic               done;
        logic               illegal;
        logic [REGBITS-1:0] readnum;
        logic [REGBITS-1:0] writenum;
        logic               write;
        logic               loada;
        logic               loadb;
        logic               loadc;
        logic               loads;
        logic               asel;
        logic               bsel;
        logic               vsel;
        logic               addsub;
        logic               andv;
        logic               notb;
        logic               sub;
    } ctrl_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;
    logic [15:0] ir_nxt;
    ctrl_t       ctrl;

    function automatic kind_t decode_kind(input logic [15:0] w);
        kind_t k;
        case ({w[15:13], w[12:11]})
            5'b110_10: k = K_MOVI;
            5'b110_00: k = K_MOV;
            5'b101_00: k = K_ADD;
            5'b101_01: k = K_CMP;
            5'b101_10: k = K_AND;
            5'b101_11: k = K_MVN;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    // Control word for a given state and latched instruction; all-zero in IDLE.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [15:0] w);
        ctrl_t c;
        kind_t k;
        c      = '0;
        k      = decode_kind(w);
        c.busy = (s != S_IDLE);
        case (s)
            S_GET_A: begin
                c.readnum = REGBITS'(w[10:8]);
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = REGBITS'(w[2:0]);
                c.loadb   = 1'b1;
            end
            S_EXEC: begin
                c.loadc = 1'b1;
                c.loads = (k == K_ADD) || (k == K_CMP);
                case (k)
                    K_ADD: c.addsub = 1'b1;
                    K_CMP: begin
                        c.addsub = 1'b1;
                        c.sub    = 1'b1;
                    end
                    K_AND: c.andv = 1'b1;
                    K_MVN: c.notb = 1'b1;
                    K_MOV: begin
                        c.addsub = 1'b1;
                        c.asel   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WRITE: begin
                c.writenum = REGBITS'(w[7:5]);
                c.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                c.writenum = REGBITS'(w[10:8]);
                c.vsel     = 1'b1;
                c.write    = 1'b1;
            end
            S_DONE: begin
                c.done    = 1'b1;
                c.illegal = (k == K_ILL);
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ir_nxt    = instr;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (decode_kind(ir))
                    K_MOVI:        state_nxt = S_WRITE_IMM;
                    K_MOV, K_MVN:  state_nxt = S_GET_B;
                    K_ILL:         state_nxt = S_DONE;
                    default:       state_nxt = S_GET_A;
                endcase
            end
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_EXEC;
            S_EXEC:      state_nxt = (decode_kind(ir) == K_CMP) ? S_DONE : S_WRITE;
            S_WRITE:     state_nxt = S_DONE;
            S_WRITE_IMM: state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they equal a Moore decode of the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            ir    <= '0;
            ctrl  <= '0;
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
            ctrl  <= ctrl_of(state_nxt, ir_nxt);
        end
    end

    assign busy       = ctrl.busy;
    assign done       = ctrl.done;
    assign illegal    = ctrl.illegal;
    assign readnum    = ctrl.readnum;
    assign writenum   = ctrl.writenum;
    assign write      = ctrl.write;
    assign loada      = ctrl.loada;
    assign loadb      = ctrl.loadb;
    assign loadc      = ctrl.loadc;
    assign loads      = ctrl.loads;
    assign asel       = ctrl.asel;
    assign bsel       = ctrl.bsel;
    assign vsel       = ctrl.vsel;
    assign addSubVals = ctrl.addsub;
    assign andVals    = ctrl.andv;
    assign notBVal    = ctrl.notb;
    assign sub        = ctrl.sub;
    assign shift      = ir[4:3];
    assign sximm      = {{(WIDTH-8){ir[7]}}, ir[7:0]};

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instrCount <= '0;
            cycleCount <= '0;
        end else begin
            if (ctrl.done && !ctrl.illegal) begin
                instrCount <= instrCount + 16'd1;
            end
            if (ctrl.busy) begin
                cycleCount <= cycleCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit RISC datapath: regfile, A/B/C pipeline registers, status register, and the add/sub/and/not-B operation unit.
- Accepts one instruction per start/done handshake, latches and decodes it.
- Drives register-file addressing, load enables, operand muxes and the operation unit's select lines (addSubVals, andVals, notBVal, sub) cycle by cycle.
- Sits between instruction fetch and the datapath.

Parameters:
- WIDTH, 16, datapath width; also the sign-extended immediate width (min 9).
- REGBITS, 3, register-number width (8 registers).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request to execute instr; sampled only in IDLE
- instr  in  16  instruction: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- illegal  out  1  valid with done; unsupported opcode/op
- readnum  out  REGBITS  regfile read address
- writenum  out  REGBITS  regfile write address
- write  out  1  regfile write enable
- loada, loadb, loadc, loads  out  1 each  A/B/C/status register load enables
- asel  out  1  1 = A operand forced to zero
- bsel  out  1  1 = B operand from sximm
- vsel  out  1  regfile write-back source: 0 = C, 1 = sximm
- shift  out  2  shifter control, instr[4:3] from latched copy
- sximm  out  WIDTH  imm8 sign-extended to WIDTH
- addSubVals, andVals, notBVal, sub  out  1 each  operation-unit selects

Behaviour:
- Reset: state IDLE; ir cleared; every output 0.
  - reset_n low mid-instruction aborts immediately.
  - No write or done is issued for the aborted instruction.
- IDLE: when start=1, latch instr into ir and go to DECODE. start is ignored in all other states; no queueing.
- Decode, from ir:
  - opcode 110, op 10: MOVI, Rn = sximm
  - opcode 110, op 00: MOV, Rd = sh(Rm)
  - opcode 101, op 00: ADD, Rd = Rn + sh(Rm)
  - opcode 101, op 01: CMP, status from Rn - sh(Rm), no write
  - opcode 101, op 10: AND, Rd = Rn & sh(Rm)
  - opcode 101, op 11: MVN, Rd = ~sh(Rm)
  - Anything else is illegal.
- Paths:
  - MOVI: DECODE > WRITE_IMM > DONE
  - MOV, MVN: DECODE > GET_B > EXEC > WRITE > DONE
  - ADD, AND: DECODE > GET_A > GET_B > EXEC > WRITE > DONE
  - CMP: DECODE > GET_A > GET_B > EXEC > DONE
  - Illegal: DECODE > DONE with illegal=1
  - DONE > IDLE unconditionally.
- Per-state outputs; unlisted outputs are 0 and ALU selects are 0 outside EXEC:
  - GET_A: readnum=Rn, loada=1
  - GET_B: readnum=Rm, loadb=1
  - EXEC, general: loadc=1, plus loads=1 for ADD/CMP only
  - EXEC, ADD: addSubVals=1
  - EXEC, CMP: addSubVals=1, sub=1
  - EXEC, AND: andVals=1
  - EXEC, MVN: notBVal=1
  - EXEC, MOV: addSubVals=1, asel=1 (0 + B)
  - WRITE: writenum=Rd, vsel=0, write=1
  - WRITE_IMM: writenum=Rn, vsel=1, write=1
  - DONE: done=1
- Exactly one of addSubVals/andVals/notBVal is high in EXEC. sub is high only with addSubVals.
- Outputs are Moore: decoded from state and ir, glitch-free relative to clk.
- Latency from the start-sampling edge to the done-high cycle:
  - ADD/AND: 6 cycles
  - CMP, MOV/MVN: 5 cycles
  - MOVI: 3 cycles
  - illegal: 2 cycles
- busy=0 only in IDLE. A new start is accepted the cycle after done.
- sximm = {{(WIDTH-8){ir[7]}}, ir[7:0]}; held constant for the whole instruction.
- instr changing while busy has no effect, since ir is latched.

Optional Feature:
- SEQ_PERF_CNT_EN.
- Defined:
  - Adds output instrCount (16 bits) and output cycleCount (16 bits), both reset to 0.
  - instrCount increments on each done with illegal=0.
  - cycleCount increments every cycle busy=1.
  - Both wrap from 0xFFFF to 0 silently.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then MOVI R3,#0x85 (instr=16'hD385) with start=1 -> write=1, writenum=3, vsel=1, sximm=16'hFF85 on cycle 2; done on cycle 3; busy=0 on cycle 4.
- ADD R2,R1,R0 (instr=16'hA140) -> GET_A readnum=1 loada; GET_B readnum=0 loadb; EXEC addSubVals=1 sub=0 loadc loads; WRITE writenum=2; done at cycle 6.
- CMP R5,R6 (16'hAD06) -> EXEC addSubVals=1 sub=1 loads=1; write stays 0 throughout; done at cycle 5.
- MVN R7,R4 shift=01 (16'hB8EC) -> GET_A skipped; EXEC notBVal=1 only; shift=01; write to R7; done at cycle 5.
- Illegal opcode 16'h0000 -> done=1 and illegal=1 at cycle 2; write never asserted. Then start held high during a busy ADD -> the second instr is ignored until IDLE.
- Assert reset_n=0 during EXEC of ADD -> all outputs 0 asynchronously; after release, IDLE with no done. With SEQ_PERF_CNT_EN, instrCount is unchanged by the aborted and illegal instructions.
